// File: rtl/tag_ram_nway_lookup.sv
// N-way set-associative tag store with per-entry valid bits and a registered hit vector.
// A sweep FSM clears all valid bits after reset or flush before lookups are accepted.
module tag_ram_nway_lookup #(
  parameter  int AWIDTH = 3,
  parameter  int TWIDTH = 7,
  parameter  int WAYS   = 2,
  localparam int WWIDTH = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  output logic                   init_done,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AWIDTH-1:0]      req_index,
  input  logic [TWIDTH-1:0]      req_tag,
  output logic                   lkp_valid,
  output logic                   lkp_hit,
  output logic [WAYS-1:0]        lkp_way,
  output logic                   lkp_multi,
  output logic [WAYS*TWIDTH-1:0] lkp_tags,
  output logic [WAYS-1:0]        lkp_vbits,
  input  logic                   wr_en,
  input  logic [AWIDTH-1:0]      wr_index,
  input  logic [WWIDTH-1:0]      wr_way,
  input  logic [TWIDTH-1:0]      wr_tag,
  input  logic                   wr_vbit
);

  localparam int DEPTH = 1 << AWIDTH;

  typedef enum logic {INIT, RUN} state_t;

  state_t                   state;
  logic [AWIDTH-1:0]        sweep_cnt;
  logic [TWIDTH-1:0]        tag_mem  [DEPTH][WAYS];
  logic [WAYS-1:0]          vbit_mem [DEPTH];

  logic                     running;
  logic                     accept;
  logic                     wr_ok;
  logic [WAYS-1:0]          wr_sel;
  logic [WAYS-1:0]          rd_vbits;
  logic [WAYS-1:0]          match;
  logic [WAYS*TWIDTH-1:0]   rd_tags;
  logic [3:0]               match_cnt;

  assign running   = (state == RUN);
  assign req_ready = running & ~flush;
  assign accept    = req_valid & req_ready;
  assign wr_ok     = wr_en & running & ~flush;

  // Write-first bypass: a same-cycle write to the looked-up set replaces that way's stored entry.
  always_comb begin
    wr_sel    = '0;
    rd_vbits  = '0;
    rd_tags   = '0;
    match     = '0;
    match_cnt = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      wr_sel[w] = wr_ok & (32'(wr_way) == w);
      if (wr_sel[w] && (wr_index == req_index)) begin
        rd_tags[w*TWIDTH +: TWIDTH] = wr_tag;
        rd_vbits[w]                 = wr_vbit;
      end else begin
        rd_tags[w*TWIDTH +: TWIDTH] = tag_mem[req_index][w];
        rd_vbits[w]                 = vbit_mem[req_index][w];
      end
      match[w]  = rd_vbits[w] & (rd_tags[w*TWIDTH +: TWIDTH] == req_tag);
      match_cnt = match_cnt + 4'(match[w]);
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (wr_sel[w]) tag_mem[wr_index][w] <= wr_tag;
    end
  end

  always_ff @(posedge clock) begin
    if (!running) begin
      vbit_mem[sweep_cnt] <= '0;
    end else begin
      for (int unsigned w = 0; w < WAYS; w++) begin
        if (wr_sel[w]) vbit_mem[wr_index][w] <= wr_vbit;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      sweep_cnt <= '0;
      init_done <= 1'b0;
      lkp_valid <= 1'b0;
      lkp_hit   <= 1'b0;
      lkp_way   <= '0;
      lkp_multi <= 1'b0;
      lkp_tags  <= '0;
      lkp_vbits <= '0;
    end else begin
      if (state == INIT) begin
        sweep_cnt <= sweep_cnt + 1'b1;
        if (sweep_cnt == '1) begin
          state     <= RUN;
          init_done <= 1'b1;
        end
      end else if (flush) begin
        state     <= INIT;
        sweep_cnt <= '0;
        init_done <= 1'b0;
      end
      lkp_valid <= accept;
      if (accept) begin
        lkp_way   <= match;
        lkp_hit   <= |match;
        lkp_multi <= (match_cnt > 4'd1);
        lkp_tags  <= rd_tags;
        lkp_vbits <= rd_vbits;
      end
    end
  end

endmodule
